// File: rtl/adc_capture_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// adc_capture_ctrl_pkg
// Shared types and helpers for the ADC capture path.
//   cap_state_t  : capture sequencer states
//   adc_sample_t : packed 32-bit BRAM word holding both 12-bit channels
//   pack_sample  : builds an adc_sample_t from two raw channel samples
// ----------------------------------------------------------------------------
package adc_capture_ctrl_pkg;

    localparam int ADC_W = 12;

    typedef enum logic [1:0] {
        CAP_IDLE    = 2'd0,
        CAP_ARMED   = 2'd1,
        CAP_CAPTURE = 2'd2,
        CAP_DONE    = 2'd3
    } cap_state_t;

    // Channel 1 in the upper half-word, channel 0 in the lower half-word,
    // each right-aligned with its top nibble forced to zero.
    typedef struct packed {
        logic [3:0]       rsvd_hi;
        logic [ADC_W-1:0] ch1;
        logic [3:0]       rsvd_lo;
        logic [ADC_W-1:0] ch0;
    } adc_sample_t;

    function automatic adc_sample_t pack_sample(input logic [ADC_W-1:0] ch0,
                                                input logic [ADC_W-1:0] ch1);
        adc_sample_t s;
        s.rsvd_hi = 4'h0;
        s.ch1     = ch1;
        s.rsvd_lo = 4'h0;
        s.ch0     = ch0;
        return s;
    endfunction

endpackage

// File: rtl/adc_capture_ctrl_if.sv
// ----------------------------------------------------------------------------
// adc_capture_ctrl_if
// Simple BRAM write port carrying packed ADC samples.
//   mem_we    : write enable (one word per asserted cycle)
//   mem_addr  : word address, ADDR_W bits
//   mem_wdata : packed adc_sample_t
// Modports: master (capture controller drives), slave (BRAM side).
// ----------------------------------------------------------------------------
interface adc_capture_ctrl_if #(
    parameter int ADDR_W = 12
);
    import adc_capture_ctrl_pkg::*;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    adc_sample_t       mem_wdata;

    modport master (
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        input mem_we,
        input mem_addr,
        input mem_wdata
    );

endinterface

// File: rtl/adc_capture_ctrl_decimator.sv
// ----------------------------------------------------------------------------
// adc_decimator
// Keeps 1 of every (decim+1) valid samples while enabled.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : forces the counter to 0 so the next valid sample is kept
//   en         : decimation active
//   valid      : sample strobe
//   decim      : keep ratio minus one
//   keep       : combinational strobe, high for a sample that must be kept
// ----------------------------------------------------------------------------
module adc_decimator #(
    parameter int DECIM_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               en,
    input  logic               valid,
    input  logic [DECIM_W-1:0] decim,
    output logic               keep
);

    localparam logic [DECIM_W-1:0] CNT_ONE = {{(DECIM_W-1){1'b0}}, 1'b1};

    logic [DECIM_W-1:0] cnt_reg;
    logic [DECIM_W-1:0] cnt_next;

    assign keep = en & valid & (cnt_reg == '0);

    always_comb begin
        cnt_next = cnt_reg;
        if (load) begin
            cnt_next = '0;
        end else if (en && valid) begin
            // A kept sample reloads the skip count; skipped samples count down.
            cnt_next = (cnt_reg == '0) ? decim : (cnt_reg - CNT_ONE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// ----------------------------------------------------------------------------
// adc_capture_ctrl
// Single-shot capture of dual-channel ADC samples into a BRAM buffer.
// Armed by software, waits for a software or external-edge trigger, then
// writes cfg_len decimated samples (0 = full depth) starting at address 0.
//   clk, rst_n       : system clock, synchronous active-low reset
//   adc_valid/ch0/ch1: ADC sample stream
//   ext_trig         : external trigger level (rising edge is used)
//   cfg_arm/abort/sw_trig : single-cycle control pulses
//   cfg_trig_sel     : 0 = software trigger, 1 = external rising edge
//   cfg_len, cfg_decim : capture length and decimation, latched at arm
//   mem              : BRAM write port (master)
//   st_busy/st_done/st_count : status back to the CSR block
// ----------------------------------------------------------------------------
module adc_capture_ctrl
    import adc_capture_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int DECIM_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               adc_valid,
    input  logic [ADC_W-1:0]   adc_ch0,
    input  logic [ADC_W-1:0]   adc_ch1,
    input  logic               ext_trig,
    input  logic               cfg_arm,
    input  logic               cfg_abort,
    input  logic               cfg_sw_trig,
    input  logic               cfg_trig_sel,
    input  logic [ADDR_W-1:0]  cfg_len,
    input  logic [DECIM_W-1:0] cfg_decim,
    adc_capture_ctrl_if.master mem,
    output logic               st_busy,
    output logic               st_done,
    output logic [ADDR_W:0]    st_count
);

    localparam logic [ADDR_W:0]   FULL_DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   COUNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

    cap_state_t         state_reg;
    cap_state_t         state_next;

    // Configuration shadows, frozen at arm time
    logic [ADDR_W-1:0]  len_reg;
    logic [DECIM_W-1:0] decim_reg;
    logic               trig_sel_reg;

    logic               ext_trig_prev_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic               we_reg;
    logic [ADDR_W-1:0]  wr_addr_reg;
    adc_sample_t        wdata_reg;
    logic               done_reg;
    logic [ADDR_W:0]    count_reg;

    logic               trig_hit;
    logic               keep;
    logic               last_keep;
    logic [ADDR_W:0]    target_len;
    logic [ADDR_W:0]    count_inc;

    logic               busy;
    logic               cap_en;
    logic               arm_accept;
    logic               trig_accept;

    assign trig_hit   = trig_sel_reg ? (ext_trig & ~ext_trig_prev_reg) : cfg_sw_trig;
    assign target_len = (len_reg == '0) ? FULL_DEPTH : {1'b0, len_reg};
    assign count_inc  = count_reg + COUNT_ONE;
    // count_reg already includes every write issued so far, so the sample
    // kept now is the terminal one when it brings the total to the target.
    assign last_keep  = keep & (count_inc == target_len);

    adc_decimator #(
        .DECIM_W (DECIM_W)
    ) u_decim (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (trig_accept),
        .en    (cap_en),
        .valid (adc_valid),
        .decim (decim_reg),
        .keep  (keep)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= CAP_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; abort takes priority over every other event
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            CAP_IDLE: begin
                if (cfg_arm && !cfg_abort) state_next = CAP_ARMED;
            end
            CAP_ARMED: begin
                if (cfg_abort)     state_next = CAP_IDLE;
                else if (trig_hit) state_next = CAP_CAPTURE;
            end
            CAP_CAPTURE: begin
                if (cfg_abort)      state_next = CAP_IDLE;
                else if (last_keep) state_next = CAP_DONE;
            end
            CAP_DONE: begin
                state_next = CAP_IDLE;
            end
            default: state_next = CAP_IDLE;
        endcase
    end

    // State-decoded control outputs
    always_comb begin
        busy        = 1'b0;
        cap_en      = 1'b0;
        arm_accept  = 1'b0;
        trig_accept = 1'b0;
        unique case (state_reg)
            CAP_IDLE: begin
                arm_accept = cfg_arm & ~cfg_abort;
            end
            CAP_ARMED: begin
                busy        = 1'b1;
                trig_accept = trig_hit & ~cfg_abort;
            end
            CAP_CAPTURE: begin
                busy   = 1'b1;
                cap_en = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Datapath: shadows, write register, address and status counters.
    // A sample kept in the abort cycle is still written; the abort only
    // stops further keeps and suppresses the done flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_reg           <= '0;
            decim_reg         <= '0;
            trig_sel_reg      <= 1'b0;
            ext_trig_prev_reg <= 1'b0;
            addr_reg          <= '0;
            we_reg            <= 1'b0;
            wr_addr_reg       <= '0;
            wdata_reg         <= '0;
            done_reg          <= 1'b0;
            count_reg         <= '0;
        end else begin
            ext_trig_prev_reg <= ext_trig;
            we_reg            <= keep;

            if (keep) begin
                wr_addr_reg <= addr_reg;
                wdata_reg   <= pack_sample(adc_ch0, adc_ch1);
                // Natural ADDR_W wrap only happens on the terminal write of a
                // full-depth capture, so no location is overwritten.
                addr_reg    <= addr_reg + ADDR_ONE;
                count_reg   <= count_inc;
            end

            if (arm_accept) begin
                len_reg      <= cfg_len;
                decim_reg    <= cfg_decim;
                trig_sel_reg <= cfg_trig_sel;
                done_reg     <= 1'b0;
                count_reg    <= '0;
            end

            if (trig_accept) begin
                addr_reg <= '0;
            end

            // DONE is the cycle carrying the last write, so the flag lands
            // one cycle after it.
            if (state_reg == CAP_DONE) begin
                done_reg <= 1'b1;
            end
        end
    end

    assign mem.mem_we    = we_reg;
    assign mem.mem_addr  = wr_addr_reg;
    assign mem.mem_wdata = wdata_reg;
    assign st_busy       = busy;
    assign st_done       = done_reg;
    assign st_count      = count_reg;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// ----------------------------------------------------------------------------
// tb_adc_capture_ctrl
// Directed bench for adc_capture_ctrl with ADDR_W=4. A new ADC sample n is
// presented every cycle (ch0 = n, ch1 = 0x800 + n); expected write data is
// derived from the sample index seen on the trigger cycle.
// ----------------------------------------------------------------------------
module tb_adc_capture_ctrl;
    import adc_capture_ctrl_pkg::*;

    localparam int ADDR_W  = 4;
    localparam int DECIM_W = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               adc_valid;
    logic [11:0]        adc_ch0;
    logic [11:0]        adc_ch1;
    logic               ext_trig;
    logic               cfg_arm;
    logic               cfg_abort;
    logic               cfg_sw_trig;
    logic               cfg_trig_sel;
    logic [ADDR_W-1:0]  cfg_len;
    logic [DECIM_W-1:0] cfg_decim;
    logic               st_busy;
    logic               st_done;
    logic [ADDR_W:0]    st_count;

    adc_capture_ctrl_if #(.ADDR_W(ADDR_W)) mem_if ();

    adc_capture_ctrl #(
        .ADDR_W  (ADDR_W),
        .DECIM_W (DECIM_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .adc_valid    (adc_valid),
        .adc_ch0      (adc_ch0),
        .adc_ch1      (adc_ch1),
        .ext_trig     (ext_trig),
        .cfg_arm      (cfg_arm),
        .cfg_abort    (cfg_abort),
        .cfg_sw_trig  (cfg_sw_trig),
        .cfg_trig_sel (cfg_trig_sel),
        .cfg_len      (cfg_len),
        .cfg_decim    (cfg_decim),
        .mem          (mem_if.master),
        .st_busy      (st_busy),
        .st_done      (st_done),
        .st_count     (st_count)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_smp    = 0;
    int          trig_n   = 0;
    int          cyc      = 0;
    int          done_cyc = -1;
    int          last_wr_cyc = -1;
    logic [31:0] q_data[$];
    int          q_addr[$];
    logic        prev_valid = 1'b0;
    logic [11:0] prev_ch0   = '0;
    logic [11:0] prev_ch1   = '0;
    logic        prev_done  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int m);
        logic [11:0] c0;
        logic [11:0] c1;
        c0 = m[11:0];
        c1 = 12'h800 + m[11:0];
        return {4'h0, c1, 4'h0, c0};
    endfunction

    // Advance one clock and present the next ADC sample.
    task automatic tick();
        @(posedge clk);
        #1;
        n_smp++;
        adc_valid = 1'b1;
        adc_ch0   = n_smp[11:0];
        adc_ch1   = 12'h800 + n_smp[11:0];
    endtask

    task automatic arm(input int len, input int decim, input logic sel);
        q_data.delete();
        q_addr.delete();
        cfg_len      = ADDR_W'(len);
        cfg_decim    = DECIM_W'(decim);
        cfg_trig_sel = sel;
        cfg_arm      = 1'b1;
        tick();
        cfg_arm = 1'b0;
    endtask

    task automatic sw_trigger();
        cfg_sw_trig = 1'b1;
        trig_n      = n_smp;
        tick();
        cfg_sw_trig = 1'b0;
    endtask

    task automatic check_writes(input string tag, input int n, input int step);
        check_eq({tag, "_nwr"}, 32'(q_data.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < q_data.size()) begin
                check_eq({tag, "_addr"}, 32'(q_addr[i]), 32'(i));
                check_eq({tag, "_data"}, q_data[i], exp_word(trig_n + 1 + i * step));
            end
        end
    endtask

    // Write monitor: one line per BRAM write, plus latency and count checks.
    always @(negedge clk) begin
        cyc++;
        if (mem_if.mem_we) begin
            check_eq("lat_valid", 32'(prev_valid), 32'd1);
            check_eq("lat_data", mem_if.mem_wdata, {4'h0, prev_ch1, 4'h0, prev_ch0});
            q_data.push_back(mem_if.mem_wdata);
            q_addr.push_back(int'(mem_if.mem_addr));
            check_eq("cnt_sync", 32'(st_count), 32'(q_data.size()));
            last_wr_cyc = cyc;
            $display("write addr=%0d data=0x%08h count=%0d", mem_if.mem_addr,
                     mem_if.mem_wdata, st_count);
        end
        if (st_done && !prev_done) done_cyc = cyc;
        prev_done  = st_done;
        prev_valid = adc_valid;
        prev_ch0   = adc_ch0;
        prev_ch1   = adc_ch1;
    end

    initial begin
        int wc;
        int n_before;

        rst_n        = 1'b0;
        adc_valid    = 1'b0;
        adc_ch0      = '0;
        adc_ch1      = '0;
        ext_trig     = 1'b0;
        cfg_arm      = 1'b0;
        cfg_abort    = 1'b0;
        cfg_sw_trig  = 1'b0;
        cfg_trig_sel = 1'b0;
        cfg_len      = '0;
        cfg_decim    = '0;

        // Reset state
        repeat (3) tick();
        check_eq("rst_we",    32'(mem_if.mem_we), 32'd0);
        check_eq("rst_addr",  32'(mem_if.mem_addr), 32'd0);
        check_eq("rst_wdata", mem_if.mem_wdata, 32'd0);
        check_eq("rst_busy",  32'(st_busy), 32'd0);
        check_eq("rst_done",  32'(st_done), 32'd0);
        check_eq("rst_count", 32'(st_count), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic software-triggered capture, 5 words, no decimation
        arm(5, 0, 1'b0);
        check_eq("t1_busy_armed", 32'(st_busy), 32'd1);
        tick();
        tick();
        sw_trigger();
        repeat (12) tick();
        check_writes("t1", 5, 1);
        check_eq("t1_first_word", q_data.size() > 0 ? q_data[0] : 32'hDEAD_BEEF,
                 32'h0800_0000 + 32'(trig_n + 1) * 32'h0001_0001);
        check_eq("t1_count",    32'(st_count), 32'd5);
        check_eq("t1_done",     32'(st_done), 32'd1);
        check_eq("t1_idle",     32'(st_busy), 32'd0);
        check_eq("t1_done_lat", 32'(done_cyc - last_wr_cyc), 32'd1);

        // Decimated external-edge capture: level already high at arm is not an edge
        ext_trig = 1'b1;
        arm(4, 2, 1'b1);
        check_eq("t2_done_clr", 32'(st_done), 32'd0);
        check_eq("t2_count_clr", 32'(st_count), 32'd0);
        repeat (3) tick();
        check_eq("t2_no_early", 32'(q_data.size()), 32'd0);
        check_eq("t2_still_armed", 32'(st_busy), 32'd1);
        ext_trig = 1'b0;
        tick();
        tick();
        ext_trig = 1'b1;
        trig_n   = n_smp;
        tick();
        repeat (20) tick();
        check_writes("t2", 4, 3);
        check_eq("t2_count", 32'(st_count), 32'd4);
        check_eq("t2_done",  32'(st_done), 32'd1);

        // Full-depth capture: 16 writes, no 17th
        arm(0, 0, 1'b0);
        tick();
        sw_trigger();
        repeat (24) tick();
        check_writes("t3", 16, 1);
        check_eq("t3_count", 32'(st_count), 32'd16);
        check_eq("t3_done",  32'(st_done), 32'd1);

        // Abort after the 4th write is visible
        arm(10, 0, 1'b0);
        tick();
        sw_trigger();
        wc = 0;
        for (int k = 0; k < 20 && wc < 4; k++) begin
            tick();
            if (mem_if.mem_we) wc++;
        end
        check_eq("t4_reached4", 32'(wc), 32'd4);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        check_eq("t4_busy_drop", 32'(st_busy), 32'd0);
        repeat (5) tick();
        check_eq("t4_nwr",   32'(q_data.size()), 32'd5);
        check_eq("t4_count", 32'(st_count), 32'd5);
        check_eq("t4_done",  32'(st_done), 32'd0);
        // Re-arm after abort
        arm(2, 0, 1'b0);
        tick();
        sw_trigger();
        repeat (8) tick();
        check_writes("t4b", 2, 1);
        check_eq("t4b_done", 32'(st_done), 32'd1);

        // Trigger in the arm cycle is ignored
        q_data.delete();
        q_addr.delete();
        cfg_len     = 4'd3;
        cfg_arm     = 1'b1;
        cfg_sw_trig = 1'b1;
        tick();
        cfg_arm     = 1'b0;
        cfg_sw_trig = 1'b0;
        repeat (4) tick();
        check_eq("t5_armed", 32'(st_busy), 32'd1);
        check_eq("t5_nwr",   32'(q_data.size()), 32'd0);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        check_eq("t5_abort_armed", 32'(st_busy), 32'd0);
        // Arm and abort together in IDLE
        cfg_arm   = 1'b1;
        cfg_abort = 1'b1;
        tick();
        cfg_arm   = 1'b0;
        cfg_abort = 1'b0;
        tick();
        check_eq("t5_arm_abort", 32'(st_busy), 32'd0);

        // Re-arm and cfg_len change during capture are ignored
        arm(6, 0, 1'b0);
        tick();
        sw_trigger();
        tick();
        tick();
        cfg_arm = 1'b1;
        cfg_len = 4'd2;
        tick();
        cfg_arm = 1'b0;
        repeat (12) tick();
        check_writes("t6", 6, 1);
        check_eq("t6_count", 32'(st_count), 32'd6);
        check_eq("t6_done",  32'(st_done), 32'd1);

        // Reset in the middle of a capture
        arm(10, 0, 1'b0);
        tick();
        sw_trigger();
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        check_eq("t7_we",    32'(mem_if.mem_we), 32'd0);
        check_eq("t7_addr",  32'(mem_if.mem_addr), 32'd0);
        check_eq("t7_wdata", mem_if.mem_wdata, 32'd0);
        check_eq("t7_busy",  32'(st_busy), 32'd0);
        check_eq("t7_done",  32'(st_done), 32'd0);
        check_eq("t7_count", 32'(st_count), 32'd0);
        n_before = q_data.size();
        repeat (3) tick();
        check_eq("t7_no_more_wr", 32'(q_data.size()), 32'(n_before));
        rst_n = 1'b1;
        repeat (3) tick();
        check_eq("t7_stay_idle", 32'(st_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
Sequences single-shot capture of dual-channel 12-bit ADC samples into a BRAM sample buffer. The block is armed by software, waits for a trigger, then writes a programmed number of decimated samples as packed 32-bit adc_sample_t words through a simple BRAM write port. Completion and progress are reported back to the CSR block. It sits between the ADC front-end and the capture BRAM, in the system clock domain.

Parameters:
- ADDR_W, 12, BRAM word-address width; buffer depth = 2**ADDR_W words.
- DECIM_W, 8, width of the decimation control field.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, reset. Synchronous, active-low.
- adc_valid, in, 1, ADC sample strobe.
- adc_ch0, in, 12, channel 0 sample.
- adc_ch1, in, 12, channel 1 sample.
- ext_trig, in, 1, external trigger, synchronous to clk, level input.
- cfg_arm, in, 1, single-cycle arm pulse.
- cfg_abort, in, 1, single-cycle abort pulse.
- cfg_sw_trig, in, 1, single-cycle software trigger.
- cfg_trig_sel, in, 1, trigger source: 0 = software, 1 = external rising edge.
- cfg_len, in, ADDR_W, number of words to capture; 0 means the full depth.
- cfg_decim, in, DECIM_W, keep 1 of every (cfg_decim+1) valid samples.
- mem_we, out, 1, BRAM write enable.
- mem_addr, out, ADDR_W, BRAM write address.
- mem_wdata, out, 32, packed adc_sample_t.
- st_busy, out, 1, high in ARMED or CAPTURE.
- st_done, out, 1, sticky; set on a completed capture.
- st_count, out, ADDR_W+1, number of words written in the current or last capture.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; the trigger-edge register is 0.
- FSM states: IDLE, ARMED, CAPTURE, DONE.
- IDLE -> ARMED on cfg_arm.
  - On this transition: clear st_done and st_count.
  - Latch cfg_len, cfg_decim and cfg_trig_sel into shadow registers. Configuration changes after arm have no effect on the capture in progress.
- ARMED -> CAPTURE on the selected trigger:
  - software source: cfg_sw_trig.
  - external source: ext_trig high this cycle and low the previous cycle.
  - On entry to CAPTURE: reset the decimation counter to 0 and the write address to 0.
- A trigger in the same cycle as cfg_arm is ignored. The earliest accepted trigger is the cycle after arm.
- A trigger while in IDLE or CAPTURE is ignored.
- CAPTURE, decimation:
  - Each adc_valid cycle: if the decimation counter is 0, the sample is kept; the counter then wraps to cfg_decim.
  - Otherwise the counter decrements.
  - The first valid sample after the trigger is always kept.
- CAPTURE, write timing:
  - A kept sample appears one cycle later as mem_we=1, with mem_addr set to the current write address.
  - mem_wdata fields: adc_ch1 at [27:16], adc_ch0 at [11:0], bits [31:28] and [15:12] zero.
  - st_count increments in the same cycle as mem_we.
- Write latency is fixed at 1 clk from adc_valid to mem_we. mem_we is never asserted outside CAPTURE, except for the final write of a capture, which still issues.
- CAPTURE -> DONE when the kept-sample count reaches the target length, where the target is cfg_len, or 2**ADDR_W when cfg_len is 0.
  - The last write issues on the transition cycle.
  - st_done is set in the cycle after the last mem_we.
- DONE -> IDLE unconditionally on the next cycle. st_done stays high until the next arm or reset.
- Full depth: the write address wraps from 2**ADDR_W-1 to 0 only at the terminal count. No overwrite occurs. st_count reaches 2**ADDR_W, which is why it is ADDR_W+1 bits wide.
- cfg_abort in ARMED or CAPTURE:
  - Go to IDLE next cycle. Any write pending from the previous cycle still completes.
  - st_done is not set; st_count holds the partial count.
- Simultaneous abort and terminal sample: abort wins and st_done stays 0, but the final write still completes.
- cfg_arm while busy is ignored.
- Simultaneous cfg_arm and cfg_abort in IDLE: abort wins and the block stays IDLE.
- rst_n low at any time, including mid-capture: synchronous return to reset values. No further mem_we.

Decomposition:
- signal_types_pkg gains:
  - capture FSM enum type cap_state_t.
  - localparam ADC_W = 12.
  - a helper function to pack channel samples into adc_sample_t.
- One sub-module is natural: adc_decimator. It holds the counter and issues the keep strobe, and is reusable for DAC-side rate control.
- The FSM, address counter and write register stay in adc_capture_ctrl.

Test Plan:
- Basic software-triggered capture:
  - Stimulus: ADDR_W=4, cfg_len=5, cfg_decim=0, software trigger; arm; trigger 3 clk later; adc_valid every cycle with ch0=n, ch1=0x800+n.
  - Response: exactly 5 writes at addresses 0..4; first mem_wdata = 0x0800_0000 + n0*0x0001_0001; st_count=5; st_done rises 1 clk after the last write.
- Decimated external-edge capture:
  - Stimulus: cfg_decim=2, external source; ext_trig held high from before arm, then low, then high.
  - Response: no capture until the second rising edge; then samples 0, 3, 6 … are written; the adc_valid-to-mem_we latency is always 1.
- Full-depth wrap:
  - Stimulus: cfg_len=0 with ADDR_W=4.
  - Response: 16 writes at addresses 0..15; no 17th write; st_count=16; st_done=1.
- Abort mid-capture:
  - Stimulus: cfg_len=10; abort after the 4th write.
  - Response: at most 5 writes total; st_done=0; st_count equals the number of writes; st_busy=0 within 1 clk; a new arm works afterwards.
- Edge cases:
  - Arm and trigger in the same cycle -> trigger ignored.
  - Arm while CAPTURE -> ignored.
  - cfg_len changed mid-capture -> the original length is kept.
  - rst_n low mid-capture -> all outputs 0 next clk.
